// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// alu_sequencer_if : instruction request / result response bundle
// Revision 1.0
// ============================================================================
interface alu_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              ins_valid;
  logic              ins_ready;
  logic [15:0]       ins_data;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic              res_err;

  modport master (
    output ins_valid, ins_data, res_ready,
    input  ins_ready, res_valid, res_data, res_carry, res_err
  );

  modport slave (
    input  ins_valid, ins_data, res_ready,
    output ins_ready, res_valid, res_data, res_carry, res_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// alu_sequencer : decodes instructions, drives an external 8-bit ALU and
//                 writes results back into a 4x8 register file
// Revision 1.0
// ============================================================================
module alu_sequencer #(
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  alu_sequencer_if.slave         bus,
  output logic [DATA_W-1:0]      alu_i_1,
  output logic [DATA_W-1:0]      alu_i_2,
  output logic [2:0]             alu_op_code,
  output logic                   alu_carry_ce,
  input  wire logic [DATA_W-1:0] alu_o_main,
  input  wire logic              alu_carry_out,
  input  wire logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0]      dbg_data
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_LDI = 3'b110;
  localparam logic [2:0] c_OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_regs [4];
  logic              r_carry;
  logic [1:0]        r_rd;
  logic [DATA_W-1:0] r_alu_i_1;
  logic [DATA_W-1:0] r_alu_i_2;
  logic [2:0]        r_alu_op;
  logic              r_alu_ce;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_err;

  logic [2:0]        w_op;
  logic [1:0]        w_rd;
  logic [1:0]        w_rs1;
  logic [1:0]        w_rs2;
  logic              w_cin;
  logic [DATA_W-1:0] w_imm;
  logic              w_accept;
  logic              w_addsub;
  logic              w_exec_addsub;

  assign w_op   = bus.ins_data[15:13];
  assign w_rd   = bus.ins_data[12:11];
  assign w_rs1  = bus.ins_data[10:9];
  assign w_rs2  = bus.ins_data[8:7];
  assign w_cin  = bus.ins_data[6];
  assign w_imm  = bus.ins_data[DATA_W-1:0];

  assign w_accept      = bus.ins_valid && (r_state == S_IDLE);
  assign w_addsub      = (w_op == c_OP_ADD) || (w_op == c_OP_SUB);
  assign w_exec_addsub = (r_alu_op == c_OP_ADD) || (r_alu_op == c_OP_SUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (bus.res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands are read in IDLE, so an instruction with rd==rs1 sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      r_carry     <= 1'b0;
      r_rd        <= 2'd0;
      r_alu_i_1   <= '0;
      r_alu_i_2   <= '0;
      r_alu_op    <= 3'd0;
      r_alu_ce    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_op <= w_op;
            r_rd     <= w_rd;
            r_alu_ce <= w_cin && r_carry && w_addsub;
            if (w_op == c_OP_LDI) begin
              r_alu_i_1 <= w_imm;
              r_alu_i_2 <= '0;
            end else begin
              r_alu_i_1 <= r_regs[w_rs1];
              r_alu_i_2 <= r_regs[w_rs2];
            end
          end
        end
        S_EXEC: begin
          r_res_valid <= 1'b1;
          if (r_alu_op == c_OP_ILL) begin
            r_res_data <= '0;
            r_res_err  <= 1'b1;
          end else begin
            r_regs[r_rd] <= alu_o_main;
            r_res_data   <= alu_o_main;
            r_res_err    <= 1'b0;
            if (w_exec_addsub) r_carry <= alu_carry_out;
          end
        end
        S_RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ins_ready = (r_state == S_IDLE);
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_carry = r_carry;
  assign bus.res_err   = r_res_err;

  assign alu_i_1      = r_alu_i_1;
  assign alu_i_2      = r_alu_i_2;
  assign alu_op_code  = r_alu_op;
  assign alu_carry_ce = r_alu_ce;

  assign dbg_data = r_regs[dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_sequencer : directed-vector bench with a behavioural ALU attached
// Revision 1.0
// ============================================================================
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] alu_i_1, alu_i_2, alu_o_main, dbg_data;
  logic [2:0] alu_op_code;
  logic       alu_carry_ce, alu_carry_out;
  logic [1:0] dbg_sel;
  int         n_vec;
  int         n_err;

  alu_sequencer_if #(.DATA_W(8)) bus ();

  alu_sequencer #(.DATA_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .alu_i_1       (alu_i_1),
    .alu_i_2       (alu_i_2),
    .alu_op_code   (alu_op_code),
    .alu_carry_ce  (alu_carry_ce),
    .alu_o_main    (alu_o_main),
    .alu_carry_out (alu_carry_out),
    .dbg_sel       (dbg_sel),
    .dbg_data      (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the ALU; SUB reports borrow. Illegal op yields junk that must not land.
  always_comb begin
    {alu_carry_out, alu_o_main} = 9'h000;
    case (alu_op_code)
      3'b000:  {alu_carry_out, alu_o_main} = {1'b0, alu_i_1} + {1'b0, alu_i_2} + {8'h00, alu_carry_ce};
      3'b001:  {alu_carry_out, alu_o_main} = {1'b0, alu_i_1} - {1'b0, alu_i_2} - {8'h00, alu_carry_ce};
      3'b010:  alu_o_main = alu_i_1 & alu_i_2;
      3'b011:  alu_o_main = alu_i_1 | alu_i_2;
      3'b100:  alu_o_main = alu_i_1 ^ alu_i_2;
      3'b101:  alu_o_main = ~alu_i_1;
      3'b110:  alu_o_main = alu_i_1;
      default: {alu_carry_out, alu_o_main} = 9'h1EE;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2,
                                      input logic cin);
    return {op, rd, rs1, rs2, cin, 6'b000000};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b110, rd, 3'b000, imm};
  endfunction

  // Returns #1 after the accepting edge, i.e. with the DUT in EXEC.
  task automatic send(input logic [15:0] w);
    @(negedge clk);
    bus.ins_valid = 1'b1;
    bus.ins_data  = w;
    for (int i = 0; i < 20; i++) begin
      if (bus.ins_ready) break;
      @(negedge clk);
    end
    chk("send_ready", 32'(bus.ins_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.ins_valid = 1'b0;
    bus.ins_data  = 16'h0000;
  endtask

  task automatic run(input string tag, input logic [15:0] w, input logic [7:0] ed,
                     input logic ec, input logic ee, input logic ece);
    send(w);
    chk({tag, "_exec_vld"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_exec_op"}, 32'(alu_op_code), 32'(w[15:13]));
    chk({tag, "_exec_ce"}, 32'(alu_carry_ce), 32'(ece));
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, 32'(bus.res_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.res_data), 32'(ed));
    chk({tag, "_carry"}, 32'(bus.res_carry), 32'(ec));
    chk({tag, "_err"}, 32'(bus.res_err), 32'(ee));
    @(posedge clk);
    #1;
    chk({tag, "_done"}, 32'(bus.res_valid), 32'd0);
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    dbg_sel = sel;
    #1;
    chk(tag, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.ins_valid = 1'b0;
    bus.ins_data  = 16'h0000;
    bus.res_ready = 1'b1;
    dbg_sel       = 2'd0;
    #12;
    chk("rst_ins_ready", 32'(bus.ins_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_carry", 32'(bus.res_carry), 32'd0);
    chk("rst_res_err", 32'(bus.res_err), 32'd0);
    chk("rst_alu_i_1", 32'(alu_i_1), 32'd0);
    chk("rst_alu_op", 32'(alu_op_code), 32'd0);
    chk("rst_dbg", 32'(dbg_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("ldi_r0", ldi(2'd0, 8'h80), 8'h80, 1'b0, 1'b0, 1'b0);
    run("ldi_r1", ldi(2'd1, 8'h80), 8'h80, 1'b0, 1'b0, 1'b0);
    run("add_ovf", enc(3'b000, 2'd2, 2'd0, 2'd1, 1'b0), 8'h00, 1'b1, 1'b0, 1'b0);
    chk_reg("dbg_r2_ovf", 2'd2, 8'h00);
    chk_reg("dbg_r0_80", 2'd0, 8'h80);

    run("ldi_r0_02", ldi(2'd0, 8'h02), 8'h02, 1'b1, 1'b0, 1'b0);
    run("ldi_r1_03", ldi(2'd1, 8'h03), 8'h03, 1'b1, 1'b0, 1'b0);
    run("add_cin1", enc(3'b000, 2'd3, 2'd0, 2'd1, 1'b1), 8'h06, 1'b0, 1'b0, 1'b1);
    run("add_cin0", enc(3'b000, 2'd3, 2'd0, 2'd1, 1'b0), 8'h05, 1'b0, 1'b0, 1'b0);

    run("ldi_r0_ff", ldi(2'd0, 8'hFF), 8'hFF, 1'b0, 1'b0, 1'b0);
    run("ldi_r1_01", ldi(2'd1, 8'h01), 8'h01, 1'b0, 1'b0, 1'b0);
    run("add_set_c", enc(3'b000, 2'd2, 2'd0, 2'd1, 1'b0), 8'h00, 1'b1, 1'b0, 1'b0);
    run("ldi_r0_4a", ldi(2'd0, 8'h4A), 8'h4A, 1'b1, 1'b0, 1'b0);
    run("ldi_r1_f7", ldi(2'd1, 8'hF7), 8'hF7, 1'b1, 1'b0, 1'b0);
    run("and", enc(3'b010, 2'd2, 2'd0, 2'd1, 1'b1), 8'h42, 1'b1, 1'b0, 1'b0);
    run("or", enc(3'b011, 2'd2, 2'd0, 2'd1, 1'b1), 8'hFF, 1'b1, 1'b0, 1'b0);
    run("xor", enc(3'b100, 2'd2, 2'd0, 2'd1, 1'b1), 8'hBD, 1'b1, 1'b0, 1'b0);
    run("not", enc(3'b101, 2'd2, 2'd0, 2'd1, 1'b1), 8'hB5, 1'b1, 1'b0, 1'b0);

    run("ldi_r0_03", ldi(2'd0, 8'h03), 8'h03, 1'b1, 1'b0, 1'b0);
    run("ldi_r1_03b", ldi(2'd1, 8'h03), 8'h03, 1'b1, 1'b0, 1'b0);
    run("sub_eq", enc(3'b001, 2'd2, 2'd0, 2'd1, 1'b0), 8'h00, 1'b0, 1'b0, 1'b0);
    run("add_rd_rs1", enc(3'b000, 2'd0, 2'd0, 2'd1, 1'b0), 8'h06, 1'b0, 1'b0, 1'b0);
    chk_reg("dbg_r0_06", 2'd0, 8'h06);

    // Response stall with a competing instruction on offer
    @(negedge clk);
    bus.res_ready = 1'b0;
    send(ldi(2'd1, 8'h11));
    @(negedge clk);
    bus.ins_valid = 1'b1;
    bus.ins_data  = ldi(2'd3, 8'h77);
    dbg_sel       = 2'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_vld", 32'(bus.res_valid), 32'd1);
      chk("stall_data", 32'(bus.res_data), 32'h11);
      chk("stall_ready", 32'(bus.ins_ready), 32'd0);
      chk("stall_r3", 32'(dbg_data), 32'h05);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_rel_vld", 32'(bus.res_valid), 32'd0);
    chk("stall_rel_ready", 32'(bus.ins_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("next_acc_ready", 32'(bus.ins_ready), 32'd0);
    chk("next_acc_op", 32'(alu_op_code), 32'd6);
    chk("next_acc_i1", 32'(alu_i_1), 32'h77);
    bus.ins_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("next_acc_data", 32'(bus.res_data), 32'h77);
    @(posedge clk);
    #1;
    chk_reg("dbg_r3_77", 2'd3, 8'h77);
    chk_reg("dbg_r1_11", 2'd1, 8'h11);

    run("ldi_r0_ff2", ldi(2'd0, 8'hFF), 8'hFF, 1'b0, 1'b0, 1'b0);
    run("ldi_r1_01b", ldi(2'd1, 8'h01), 8'h01, 1'b0, 1'b0, 1'b0);
    run("add_set_c2", enc(3'b000, 2'd2, 2'd0, 2'd1, 1'b0), 8'h00, 1'b1, 1'b0, 1'b0);
    run("illegal", enc(3'b111, 2'd1, 2'd0, 2'd1, 1'b1), 8'h00, 1'b1, 1'b1, 1'b0);
    chk("illegal_err_clr", 32'(bus.res_err), 32'd0);
    chk_reg("illegal_r1", 2'd1, 8'h01);
    run("ldi_after_ill", ldi(2'd3, 8'h55), 8'h55, 1'b1, 1'b0, 1'b0);

    // Reset while an instruction sits in EXEC
    send(ldi(2'd0, 8'h99));
    rst_n = 1'b0;
    #2;
    chk("rst_exec_ready", 32'(bus.ins_ready), 32'd1);
    chk("rst_exec_vld", 32'(bus.res_valid), 32'd0);
    chk("rst_exec_carry", 32'(bus.res_carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_exec_no_resp", 32'(bus.res_valid), 32'd0);
    for (int r = 0; r < 4; r++) chk_reg("rst_exec_reg", 2'(r), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
